multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 4: number of independent key channels, at least 1.
REQ-002 Parameter DB_COUNT, default 100000: lock-out length in clock cycles after each accepted edge, at least 2.
REQ-003 Parameter CNT_W, default 17: lock-out counter width; 2^CNT_W >= DB_COUNT SHALL hold.
REQ-004 Parameter REPEAT_DLY, default 50000000: held-key cycles before the first auto-repeat pulse, used only with DEBOUNCE_REPEAT_EN.
REQ-005 Parameter REPEAT_PER, default 10000000: cycles between later auto-repeat pulses, used only with DEBOUNCE_REPEAT_EN.
REQ-006 ck  input  1  rising-edge system clock.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 key  input  N_CH  raw asynchronous bouncing key levels, 1 = pressed.
REQ-009 stable  output  N_CH  debounced key level per channel.
REQ-010 press  output  N_CH  one-cycle pulse per accepted press, and per auto-repeat when compiled in.
REQ-011 rel  output  N_CH  one-cycle pulse per accepted release.

Function
REQ-012 Each key bit SHALL pass through its own 2-flop synchronizer; the second-flop value is key_s.
REQ-013 Each channel SHALL have an independent Moore FSM with states IDLE0, PRESS, WAIT1, IDLE1, RELS, WAIT0, and its own CNT_W-bit counter.
REQ-014 IDLE0: key_s=1 goes to PRESS; otherwise the FSM stays in IDLE0.
REQ-015 PRESS lasts one cycle, then goes to WAIT1.
REQ-016 WAIT1 goes to IDLE1 on hit; otherwise it stays in WAIT1.
REQ-017 IDLE1: key_s=0 goes to RELS; otherwise it stays in IDLE1.
REQ-018 RELS lasts one cycle, then goes to WAIT0.
REQ-019 WAIT0 goes to IDLE0 on hit; otherwise it stays in WAIT0.
REQ-020 key_s SHALL be ignored in PRESS, WAIT1, RELS and WAIT0; bounces during lock-out have no effect.
REQ-021 Counter behaviour:
- cleared to 0 in IDLE0, IDLE1 and RELS;
- counts +1 per cycle in PRESS, WAIT1 and WAIT0;
- saturates at DB_COUNT-1;
- hit = (counter == DB_COUNT-1).
REQ-022 Lock-out duration:
- PRESS plus WAIT1 SHALL total exactly DB_COUNT cycles;
- RELS plus WAIT0 SHALL total DB_COUNT+1 cycles.
REQ-023 Output decodes from state only:
- press = 1 in PRESS;
- rel = 1 in RELS;
- stable = 1 in PRESS, WAIT1 and IDLE1, 0 otherwise.
REQ-024 Latency: a key change set up before clock edge k SHALL produce its press or rel pulse in the cycle after edge k+2 when the FSM is idle.
REQ-025 A key released during WAIT1 SHALL produce rel exactly 2 cycles after WAIT1 ends (IDLE1 for one cycle, then RELS).
REQ-026 Channels SHALL be fully independent; simultaneous edges on any number of channels SHALL each produce their own pulses in the same cycle.
REQ-027 press and rel of one channel SHALL never be high in the same cycle.

Reset
REQ-028 While reset is high, and asynchronously on its rising edge:
- all FSMs SHALL enter IDLE0;
- counters and synchronizer flops SHALL clear to 0;
- stable, press and rel SHALL be 0.
REQ-029 Reset mid-lock-out SHALL abort the lock-out with no rel pulse.
REQ-030 A key held through reset release SHALL produce press 3 cycles after release.

Configuration
REQ-031 With macro DEBOUNCE_REPEAT_EN defined, each channel SHALL have an extra repeat counter and the following auto-repeat behaviour:
- while the channel stays in IDLE1, the counter counts cycles;
- press pulses one cycle after REPEAT_DLY cycles in IDLE1, then every REPEAT_PER cycles;
- the repeat counter clears on leaving IDLE1;
- stable stays 1 throughout.
REQ-032 Without DEBOUNCE_REPEAT_EN:
- no repeat logic SHALL be synthesized;
- REPEAT_DLY and REPEAT_PER SHALL be ignored;
- press SHALL pulse exactly once per accepted press.

Verification (all with N_CH=4, DB_COUNT=4)
REQ-033 key[0] 0->1 clean at edge 10 -> press[0]=1 for one cycle after edge 12; stable[0]=1 from the same cycle; rel[0]=0.
REQ-034 key[1] bounces 1,0,1,0,1 on successive cycles starting at edge 10, then stays 1 -> exactly one press[1] pulse (after edge 12) and no rel[1].
REQ-035 key[2] pulsed high for 1 cycle only -> one press[2] after edge k+2; rel[2] exactly 2 cycles after WAIT1 ends; stable[2] high for 5 cycles.
REQ-036 key[3:0] all rise at the same edge -> press=4'b1111 in one cycle; a later common fall -> rel=4'b1111 in one cycle.
REQ-037 reset asserted 2 cycles into WAIT1 of channel 0 -> stable=0 and no pulses immediately; if key[0] is still high, press[0] occurs 3 cycles after reset release.
REQ-038 With DEBOUNCE_REPEAT_EN, REPEAT_DLY=8, REPEAT_PER=3, key[0] held -> initial press[0], then press[0] 8 cycles after IDLE1 entry, then every 3 cycles until release.

Source files
------------

// File: rtl/multi_debounce.sv
// Per-channel key debouncer: press/rel pulse 3 edges after a clean key change, then a fixed lock-out.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a key stays held.
module multi_debounce #(
  parameter int N_CH       = 4,
  parameter int DB_COUNT   = 100000,
  parameter int CNT_W      = 17,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
) (
  input  logic            ck,
  input  logic            reset,
  input  logic [N_CH-1:0] key,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel
);

  typedef enum logic [2:0] {IDLE0, PRESS, WAIT1, IDLE1, RELS, WAIT0} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] key_s_q;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      key_s_q <= '0;
    end else begin
      sync1_q <= key;
      key_s_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             hit;
    logic             rpt_pulse;

    assign hit     = (cnt_q == CNT_MAX);
    assign cnt_inc = hit ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
        state_q <= IDLE0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // key_s is only looked at in the two idle states; everything else is lock-out.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        IDLE0: if (key_s_q[c]) state_d = PRESS;
        PRESS: begin
          cnt_d   = cnt_inc;
          state_d = WAIT1;
        end
        WAIT1: begin
          cnt_d = cnt_inc;
          if (hit) state_d = IDLE1;
        end
        IDLE1: if (!key_s_q[c]) state_d = RELS;
        RELS:  state_d = WAIT0;
        WAIT0: begin
          cnt_d = cnt_inc;
          if (hit) state_d = IDLE0;
        end
        default: state_d = IDLE0;
      endcase
    end

    assign stable[c] = (state_q == PRESS) || (state_q == WAIT1) || (state_q == IDLE1);
    assign rel[c]    = (state_q == RELS);
    assign press[c]  = (state_q == PRESS) || rpt_pulse;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY_M1 = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_M1 = RPT_W'(REPEAT_PER - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
    logic             rpt_pulse_q, rpt_pulse_d;
    logic             rpt_hit;

    assign rpt_hit = (rpt_q == (first_q ? RPT_DLY_M1 : RPT_PER_M1));

    // Only fire when the key is still held, so a repeat never lands on the RELS cycle.
    always_comb begin
      rpt_d       = '0;
      first_d     = 1'b1;
      rpt_pulse_d = 1'b0;
      if ((state_q == IDLE1) && key_s_q[c]) begin
        first_d = first_q;
        if (rpt_hit) begin
          first_d     = 1'b0;
          rpt_pulse_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
        rpt_q       <= '0;
        first_q     <= 1'b1;
        rpt_pulse_q <= 1'b0;
      end else begin
        rpt_q       <= rpt_d;
        first_q     <= first_d;
        rpt_pulse_q <= rpt_pulse_d;
      end
    end

    assign rpt_pulse = rpt_pulse_q;
`else
    assign rpt_pulse = 1'b0;
    // Repeat timing is inert without the repeat logic.
    if (REPEAT_DLY < 0 || REPEAT_PER < 0) begin : g_repeat_unused
    end
`endif
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed vector table, hand sequences for lock-out/reset/repeat,
// then random keys against an event-level reference model.
module tb_multi_debounce;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int CNTW = 3;
  localparam int RDLY = 8;
  localparam int RPER = 3;

  logic         ck = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key = '0;
  logic [N-1:0] stable, press, rel;

  multi_debounce #(
    .N_CH(N), .DB_COUNT(DB), .CNT_W(CNTW), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .ck(ck), .reset(reset), .key(key), .stable(stable), .press(press), .rel(rel)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: stable/press/rel got %b_%b_%b want %b_%b_%b", name, $time,
               act[3*N-1:2*N], act[2*N-1:N], act[N-1:0], exp[3*N-1:2*N], exp[2*N-1:N], exp[N-1:0]);
    end
  endtask

  // Reference model: a key change is accepted only from an idle cycle, then a fixed
  // number of following edges are ignored (DB after a press, DB+1 after a release).
  logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int           m_rem [N];
  int           m_hold[N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) begin
      m_rem[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (m_rem[c] > 0) begin
        m_rem[c]--;
      end else if (m_s2[c] != m_lvl[c]) begin
        m_lvl[c]  = m_s2[c];
        m_hold[c] = 0;
        if (m_s2[c]) begin
          m_press[c] = 1'b1;
          m_rem[c]   = DB;
        end else begin
          m_rel[c] = 1'b1;
          m_rem[c] = DB + 1;
        end
      end
`ifdef DEBOUNCE_REPEAT_EN
      else if (m_lvl[c]) begin
        m_hold[c]++;
        if (m_hold[c] == RDLY || (m_hold[c] > RDLY && (m_hold[c] - RDLY) % RPER == 0))
          m_press[c] = 1'b1;
      end
`endif
    end
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  task automatic tick();
    @(posedge ck);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_async", {stable, press, rel}, '0);
    repeat (hold) begin
      tick();
      check("reset_held", {stable, press, rel}, '0);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] k;
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [N-1:0] k, input logic [N-1:0] st,
                     input logic [N-1:0] pr, input logic [N-1:0] rl);
    vec_t v;
    v.k = k; v.st = st; v.pr = pr; v.rl = rl;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] e_st, e_pr, e_rl;

    // Rows: key applied before edge i, outputs expected just after edge i.
    add(3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);  // ch0 clean rise, ch1 starts bouncing
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0011, 4'b0011, 4'b0011, 4'b0000);
    add(1, 4'b0001, 4'b0011, 4'b0000, 4'b0000);
    add(1, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    add(5, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    add(2, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0011);
    add(5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);  // common rise
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    add(4, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    add(2, 4'b0000, 4'b1111, 4'b0000, 4'b0000);  // common fall
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    add(5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    do_reset(3);

    for (int i = 0; i < vecs.size(); i++) begin
      key = vecs[i].k;
      tick();
      check($sformatf("vec%0d", i), {stable, press, rel}, {vecs[i].st, vecs[i].pr, vecs[i].rl});
    end

    // ch2 high for a single cycle: short press, then release right after lock-out.
    for (int j = 0; j < 15; j++) begin
      key = (j == 0) ? 4'b0100 : 4'b0000;
      tick();
      e_st = (j >= 2 && j <= 6) ? 4'b0100 : 4'b0000;
      e_pr = (j == 2) ? 4'b0100 : 4'b0000;
      e_rl = (j == 7) ? 4'b0100 : 4'b0000;
      check($sformatf("glitch%0d", j), {stable, press, rel}, {e_st, e_pr, e_rl});
    end

    // Reset two cycles into WAIT1 with ch0 held, then press again after release.
    key = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      tick();
      e_st = (j >= 2) ? 4'b0001 : 4'b0000;
      e_pr = (j == 2) ? 4'b0001 : 4'b0000;
      check($sformatf("prerst%0d", j), {stable, press, rel}, {e_st, e_pr, 4'b0000});
    end
    do_reset(2);
    for (int r = 1; r <= 6; r++) begin
      tick();
      e_st = (r >= 3) ? 4'b0001 : 4'b0000;
      e_pr = (r == 3) ? 4'b0001 : 4'b0000;
      check($sformatf("postrst%0d", r), {stable, press, rel}, {e_st, e_pr, 4'b0000});
    end
    key = 4'b0000;
    repeat (12) tick();

`ifdef DEBOUNCE_REPEAT_EN
    for (int j = 0; j < 34; j++) begin
      key = (j < 25) ? 4'b0001 : 4'b0000;
      tick();
      e_st = (j >= 2 && j < 27) ? 4'b0001 : 4'b0000;
      e_pr = (j == 2 || j == 14 || j == 17 || j == 20 || j == 23 || j == 26) ? 4'b0001 : 4'b0000;
      e_rl = (j == 27) ? 4'b0001 : 4'b0000;
      check($sformatf("repeat%0d", j), {stable, press, rel}, {e_st, e_pr, e_rl});
    end
    repeat (8) tick();
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) key[c] = ~key[c];
      tick();
      check("rand", {stable, press, rel}, {m_lvl, m_press, m_rel});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
